cosim_chg_collector: RTL and testbench

Assembles DUT-side change records for co-simulation against the Spike model. Per-cycle access events (register reads/writes, loads, stores) and instruction-retire events from the core are packed into one record per retired instruction. Each record holds pc, ir, op count and up to `COSIM_MAX_OP` ops, and is buffered for the checker. The checker compares each record against the change info returned by `csGetCPUChg`.

---
 rtl/cosim_pkg.sv | 46 ++++
 rtl/cosim_chg_fifo.sv | 66 ++++++
 rtl/cosim_chg_collector.sv | 110 +++++++++++
 tb/tb_cosim_chg_collector.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cosim_pkg.sv
// Co-simulation change-record types shared by the collector and its record FIFO.
// COSIM_MAX_OP sets the number of op slots carried by each record.
`ifndef COSIM_MAX_OP
`define COSIM_MAX_OP 16
`endif

package cosim_pkg;

    localparam int unsigned CsMaxOp = `COSIM_MAX_OP;

    typedef enum logic [7:0] {
        csChgAccNone     = 8'h00,
        csChgAccRdXPR    = 8'h01,
        csChgAccWrXPR    = 8'h02,
        csChgAccRdFPR    = 8'h03,
        csChgAccWrFPR    = 8'h04,
        csChgAccRdCSR    = 8'h05,
        csChgAccWrCSR    = 8'h06,
        csChgAccLDuint8  = 8'h10,
        csChgAccLDuint16 = 8'h11,
        csChgAccLDuint32 = 8'h12,
        csChgAccLDuint64 = 8'h13,
        csChgAccSTuint8  = 8'h20,
        csChgAccSTuint16 = 8'h21,
        csChgAccSTuint32 = 8'h22,
        csChgAccSTuint64 = 8'h23
    } csChgAccess_t;

    typedef struct packed {
        logic [63:0]  addr;
        logic [63:0]  data;
        csChgAccess_t access;
    } csChgOpPacked_t;

    typedef struct packed {
        logic [63:0]                    pc;
        logic [63:0]                    ir;
        logic [7:0]                     op_num;
        csChgOpPacked_t [CsMaxOp-1:0]   ops;
    } csChgRec_t;

    function automatic logic csIsRdAccess(input logic [7:0] acc);
        return (acc == csChgAccRdXPR) || (acc == csChgAccRdFPR) || (acc == csChgAccRdCSR);
    endfunction

endpackage

// File: rtl/cosim_chg_fifo.sv
// Synchronous record FIFO; head entry is read from storage through a registered pointer.
module cosim_chg_fifo
    import cosim_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  csChgRec_t                push_data,
    input  logic                     pop,
    output csChgRec_t                pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    csChgRec_t         mem [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              push_en, pop_en;

    assign full  = (count_q == CntW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so pointer increments wrap naturally.
        if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({push_en, pop_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr_q] <= push_data;
    end

    assign pop_data = empty ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/cosim_chg_collector.sv
// Packs per-cycle access events into one change record per retired instruction.
// Define COSIM_COLLECT_RD_EN to keep register-read ops; otherwise they are dropped at the input.
module cosim_chg_collector
    import cosim_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned MAX_OP = CsMaxOp
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        in_ready,
    input  logic        op_valid,
    input  logic [7:0]  op_access,
    input  logic [63:0] op_addr,
    input  logic [63:0] op_data,
    input  logic        retire_valid,
    input  logic [63:0] retire_pc,
    input  logic [63:0] retire_ir,
    output logic        rec_valid,
    input  logic        rec_ready,
    output csChgRec_t   rec,
    output logic        err_op_ovf,
    output logic        err_fifo_ovf
);

    localparam int unsigned CntW  = $clog2(MAX_OP + 1);
    localparam int unsigned FCntW = $clog2(DEPTH) + 1;

    csChgOpPacked_t [CsMaxOp-1:0] acc_ops_q, acc_ops_d, ops_now;
    logic [CntW-1:0]              acc_cnt_q, acc_cnt_d, cnt_now;
    logic                         err_op_q, err_op_d;
    logic                         err_fifo_q, err_fifo_d;
    logic                         op_keep, op_fits, op_take;
    logic                         fifo_push, fifo_full, fifo_empty;
    logic [FCntW-1:0]             fifo_count;
    csChgRec_t                    push_rec;

`ifdef COSIM_COLLECT_RD_EN
    assign op_keep = op_valid;
`else
    assign op_keep = op_valid && !csIsRdAccess(op_access);
`endif

    assign op_fits   = (acc_cnt_q < CntW'(MAX_OP));
    assign op_take   = op_keep && op_fits;
    assign in_ready  = (fifo_count != FCntW'(DEPTH));
    assign fifo_push = retire_valid && !fifo_full;

    always_comb begin
        ops_now = acc_ops_q;
        for (int i = 0; i < CsMaxOp; i++) begin
            if (op_take && (acc_cnt_q == CntW'(i))) begin
                ops_now[i] = '{addr: op_addr, data: op_data, access: csChgAccess_t'(op_access)};
            end
        end
        cnt_now = acc_cnt_q + CntW'(op_take);

        push_rec        = '0;
        push_rec.pc     = retire_pc;
        push_rec.ir     = retire_ir;
        push_rec.op_num = 8'(cnt_now);
        push_rec.ops    = ops_now;

        // A retire always closes the record, even when the FIFO drops it,
        // which keeps unused slots zero for the next record.
        if (retire_valid) begin
            acc_ops_d = '0;
            acc_cnt_d = '0;
        end else begin
            acc_ops_d = ops_now;
            acc_cnt_d = cnt_now;
        end

        err_op_d   = err_op_q || (op_keep && !op_fits);
        err_fifo_d = err_fifo_q || (retire_valid && !in_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_ops_q  <= '0;
            acc_cnt_q  <= '0;
            err_op_q   <= 1'b0;
            err_fifo_q <= 1'b0;
        end else begin
            acc_ops_q  <= acc_ops_d;
            acc_cnt_q  <= acc_cnt_d;
            err_op_q   <= err_op_d;
            err_fifo_q <= err_fifo_d;
        end
    end

    cosim_chg_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (push_rec),
        .pop       (rec_ready),
        .pop_data  (rec),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rec_valid    = !fifo_empty;
    assign err_op_ovf   = err_op_q;
    assign err_fifo_ovf = err_fifo_q;

endmodule

// File: tb/tb_cosim_chg_collector.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based record model.
module tb_cosim_chg_collector;
    import cosim_pkg::*;

    localparam int DEPTH = 4;
    localparam int MAXOP = CsMaxOp;

    logic        clk;
    logic        rst_n;
    logic        in_ready;
    logic        op_valid;
    logic [7:0]  op_access;
    logic [63:0] op_addr;
    logic [63:0] op_data;
    logic        retire_valid;
    logic [63:0] retire_pc;
    logic [63:0] retire_ir;
    logic        rec_valid;
    logic        rec_ready;
    csChgRec_t   rec;
    logic        err_op_ovf;
    logic        err_fifo_ovf;

    cosim_chg_collector #(
        .DEPTH  (DEPTH),
        .MAX_OP (MAXOP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_ready     (in_ready),
        .op_valid     (op_valid),
        .op_access    (op_access),
        .op_addr      (op_addr),
        .op_data      (op_data),
        .retire_valid (retire_valid),
        .retire_pc    (retire_pc),
        .retire_ir    (retire_ir),
        .rec_valid    (rec_valid),
        .rec_ready    (rec_ready),
        .rec          (rec),
        .err_op_ovf   (err_op_ovf),
        .err_fifo_ovf (err_fifo_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nerr = 0;
    int nchk = 0;

    // Reference model: pending ops for the next instruction, and the queued records.
    csChgRec_t      mq[$];
    csChgOpPacked_t pend[$];
    bit             m_eop;
    bit             m_efifo;

    logic [7:0] acc_tab [15];

    function automatic bit kept(input logic [7:0] a);
`ifdef COSIM_COLLECT_RD_EN
        return 1'b1;
`else
        return !(a == csChgAccRdXPR || a == csChgAccRdFPR || a == csChgAccRdCSR);
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic model_edge();
        csChgRec_t r;
        int        sz;
        bit        popn;
        sz   = mq.size();
        popn = rec_ready && (sz > 0);
        if (op_valid && kept(op_access)) begin
            if (pend.size() < MAXOP)
                pend.push_back('{addr: op_addr, data: op_data,
                                 access: csChgAccess_t'(op_access)});
            else
                m_eop = 1'b1;
        end
        if (popn) void'(mq.pop_front());
        if (retire_valid) begin
            if (sz < DEPTH) begin
                r        = '0;
                r.pc     = retire_pc;
                r.ir     = retire_ir;
                r.op_num = 8'(pend.size());
                foreach (pend[i]) r.ops[i] = pend[i];
                mq.push_back(r);
            end else begin
                m_efifo = 1'b1;
            end
            pend.delete();
        end
    endtask

    task automatic compare_all();
        csChgRec_t e;
        int        slot;
        check("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
        check("rec_valid", 64'(rec_valid), 64'(mq.size() > 0));
        check("err_op_ovf", 64'(err_op_ovf), 64'(m_eop));
        check("err_fifo_ovf", 64'(err_fifo_ovf), 64'(m_efifo));
        if (mq.size() > 0) begin
            e = mq[0];
            check("rec.pc", rec.pc, e.pc);
            check("rec.ir", rec.ir, e.ir);
            check("rec.op_num", 64'(rec.op_num), 64'(e.op_num));
            nchk++;
            if (rec.ops !== e.ops) begin
                slot = 0;
                for (int i = CsMaxOp - 1; i >= 0; i--) if (rec.ops[i] !== e.ops[i]) slot = i;
                nerr++;
                $display("FAIL rec.ops slot %0d: got %h/%h/%h want %h/%h/%h", slot,
                         rec.ops[slot].addr, rec.ops[slot].data, rec.ops[slot].access,
                         e.ops[slot].addr, e.ops[slot].data, e.ops[slot].access);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle();
        op_valid     = 1'b0;
        retire_valid = 1'b0;
    endtask

    task automatic set_op(input logic [7:0] a, input logic [63:0] ad, input logic [63:0] d);
        op_valid  = 1'b1;
        op_access = a;
        op_addr   = ad;
        op_data   = d;
    endtask

    task automatic set_ret(input logic [63:0] pc, input logic [63:0] ir);
        retire_valid = 1'b1;
        retire_pc    = pc;
        retire_ir    = ir;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #1;
        mq.delete();
        pend.delete();
        m_eop   = 1'b0;
        m_efifo = 1'b0;
        compare_all();
        check("reset.in_ready", 64'(in_ready), 64'd1);
        check("reset.rec_valid", 64'(rec_valid), 64'd0);
        check("reset.rec_nonzero", 64'(rec != '0), 64'd0);
        check("reset.errs", 64'({err_op_ovf, err_fifo_ovf}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        idle();
        rec_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) step();
        rec_ready = 1'b0;
    endtask

    initial begin
        acc_tab = '{csChgAccRdXPR, csChgAccWrXPR, csChgAccRdFPR, csChgAccWrFPR, csChgAccRdCSR,
                    csChgAccWrCSR, csChgAccLDuint8, csChgAccLDuint16, csChgAccLDuint32,
                    csChgAccLDuint64, csChgAccSTuint8, csChgAccSTuint16, csChgAccSTuint32,
                    csChgAccSTuint64, csChgAccNone};
        rst_n     = 1'b0;
        rec_ready = 1'b0;
        op_access = '0;
        op_addr   = '0;
        op_data   = '0;
        retire_pc = '0;
        retire_ir = '0;
        idle();
        do_reset();

        // Op then retire on the next cycle.
        set_op(csChgAccWrXPR, 64'd5, 64'h1234);
        step();
        check("t1.valid_before", 64'(rec_valid), 64'd0);
        idle();
        set_ret(64'h8000_0000, 64'h0050_0293);
        step();
        idle();
        check("t1.valid", 64'(rec_valid), 64'd1);
        check("t1.pc", rec.pc, 64'h8000_0000);
        check("t1.op_num", 64'(rec.op_num), 64'd1);
        check("t1.addr", rec.ops[0].addr, 64'd5);
        check("t1.data", rec.ops[0].data, 64'h1234);
        check("t1.access", 64'(rec.ops[0].access), 64'(csChgAccWrXPR));
        check("t1.slot1", rec.ops[1].addr, 64'd0);
        drain();

        // Same-cycle op and retire belong together.
        set_op(csChgAccSTuint32, 64'h8000_1000, 64'hdead_beef);
        set_ret(64'h8000_0004, 64'h00b5_2023);
        step();
        idle();
        set_ret(64'h8000_0008, 64'h0000_0013);
        step();
        idle();
        check("t2.op_num", 64'(rec.op_num), 64'd1);
        check("t2.addr", rec.ops[0].addr, 64'h8000_1000);
        rec_ready = 1'b1;
        step();
        rec_ready = 1'b0;
        check("t2.next_op_num", 64'(rec.op_num), 64'd0);
        check("t2.next_pc", rec.pc, 64'h8000_0008);
        drain();

        // Seventeen ops: the last is dropped and flags overflow.
        for (int i = 0; i < 17; i++) begin
            set_op(csChgAccWrXPR, 64'(i), 64'(i * 3));
            step();
            if (i == 15) check("t3.no_ovf_at_16", 64'(err_op_ovf), 64'd0);
        end
        check("t3.ovf", 64'(err_op_ovf), 64'd1);
        idle();
        set_ret(64'h8000_0100, 64'h1);
        step();
        idle();
        check("t3.op_num", 64'(rec.op_num), 64'd16);
        check("t3.last_addr", rec.ops[15].addr, 64'd15);
        drain();
        set_ret(64'h8000_0104, 64'h2);
        step();
        idle();
        drain();
        check("t3.ovf_sticky", 64'(err_op_ovf), 64'd1);

        // Fill the FIFO, then overflow it, then drain in order.
        for (int i = 0; i < 5; i++) begin
            set_ret(64'h1000 + 64'(i), 64'(i));
            step();
            if (i == 3) check("t4.full", 64'(in_ready), 64'd0);
        end
        idle();
        check("t4.fifo_ovf", 64'(err_fifo_ovf), 64'd1);
        rec_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t4.order", rec.pc, 64'h1000 + 64'(i));
            step();
        end
        rec_ready = 1'b0;
        check("t4.empty", 64'(rec_valid), 64'd0);

        // Read-op filtering.
        set_op(csChgAccRdXPR, 64'd7, 64'h55);
        step();
        set_op(csChgAccWrXPR, 64'd8, 64'h66);
        step();
        idle();
        set_ret(64'h8000_0200, 64'h3);
        step();
        idle();
`ifdef COSIM_COLLECT_RD_EN
        check("t5.op_num", 64'(rec.op_num), 64'd2);
        check("t5.first", 64'(rec.ops[0].access), 64'(csChgAccRdXPR));
`else
        check("t5.op_num", 64'(rec.op_num), 64'd1);
        check("t5.first", 64'(rec.ops[0].access), 64'(csChgAccWrXPR));
`endif
        drain();

        // Reset mid-record with a queued record and pending ops.
        set_ret(64'h8000_0300, 64'h4);
        step();
        set_op(csChgAccWrCSR, 64'h300, 64'h8);
        retire_valid = 1'b0;
        step();
        set_op(csChgAccWrFPR, 64'd2, 64'h9);
        step();
        do_reset();
        set_op(csChgAccLDuint64, 64'h8000_2000, 64'h77);
        set_ret(64'h8000_0400, 64'h5);
        step();
        idle();
        check("t6.op_num", 64'(rec.op_num), 64'd1);
        drain();

        // Random traffic in phases of varying back-pressure and retire rate.
        for (int c = 0; c < 3000; c++) begin
            int ph;
            ph = (c / 250) % 4;
            op_valid     = ($urandom_range(0, 1) == 1);
            op_access    = acc_tab[$urandom_range(0, 14)];
            op_addr      = {$urandom, $urandom};
            op_data      = {$urandom, $urandom};
            retire_valid = (ph == 3) ? ($urandom_range(0, 39) == 0)
                                     : ($urandom_range(0, 3) == 0);
            retire_pc    = {$urandom, $urandom};
            retire_ir    = {32'd0, $urandom};
            rec_ready    = (ph == 1) ? ($urandom_range(0, 7) == 0)
                                     : ($urandom_range(0, 3) != 0);
            step();
            if (c == 1500) do_reset();
        end
        idle();
        drain();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
